canasta_ctrl: RTL and testbench

Position controller between the UART receiver and the basket sprite. It parses framed position packets from the serial byte stream and validates them. Each accepted packet sets a clamped target column. Once per video frame, the controller moves the basket's drawn column toward that target. Its `pos_x` output drives the basket renderer, replacing the direct byte-to-position conversion path.

---
 rtl/canasta_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_canasta_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/canasta_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : canasta_ctrl
// Purpose  : Basket position controller. Parses 4-byte framed position
//            packets (AA, HI, LO, CHK) from the UART byte stream and validates
//            them. Accepted packets set a clamped target column. On each
//            frame_tick the drawn column (pos_x) moves toward that target.
// Revision : 1.0 - initial release
//
// Build option:
//   CANASTA_SLEW_EN - when defined, pos_x slews toward target_x by at most
//                     STEP pixels per frame. When undefined, pos_x jumps to
//                     target_x on each frame_tick.
//
// Ports:
//   clk        in   system clock, rising-edge
//   reset      in   asynchronous active-low reset
//   rx_valid   in   one-cycle byte strobe from the UART receiver
//   rx_data    in   received byte (valid while rx_valid is high)
//   rx_error   in   one-cycle UART framing-error strobe
//   frame_tick in   one-cycle pulse at the start of vertical blanking
//   pos_x      out  current basket column
//   target_x   out  last accepted, clamped target column
//   pkt_ok     out  one-cycle pulse when a packet is accepted
//   pkt_err    out  one-cycle pulse when a packet is rejected or aborted
//   err_count  out  saturating count of rejected packets
//   busy       out  high while a packet is partially received
// ============================================================================
module canasta_ctrl #(
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 575,
    parameter int RESET_X = 288,
    parameter int STEP    = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_error,
    input  logic       frame_tick,
    output logic [9:0] pos_x,
    output logic [9:0] target_x,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam logic [9:0]  X_MIN_V   = 10'(X_MIN);
    localparam logic [9:0]  X_MAX_V   = 10'(X_MAX);
    localparam logic [9:0]  RESET_X_V = 10'(RESET_X);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  SYNC_BYTE = 8'hAA;

    typedef enum logic [1:0] {
        S_HDR = 2'd0,
        S_HI  = 2'd1,
        S_LO  = 2'd2,
        S_CHK = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  hi_q;
    logic [7:0]  hi_nxt;
    logic [7:0]  lo_q;
    logic [7:0]  lo_nxt;
    logic        bad_q;
    logic        bad_nxt;
    logic [15:0] tmo_cnt;
    logic [15:0] tmo_nxt;
    logic        accept;
    logic        reject;
    logic        byte_ok;
    logic        timed_out;
    logic [9:0]  value;
    logic [9:0]  value_clamped;
    logic [9:0]  pos_nxt;

    // A framing error in the same cycle as a byte discards that byte.
    assign byte_ok   = rx_valid && !rx_error;
    assign timed_out = (tmo_cnt == TMO_LAST) && !rx_valid;
    assign value     = {hi_q[1:0], lo_q};

    // Clamp: "<=" / ">=" keep the comparison meaningful even when a bound
    // sits at the edge of the 10-bit range.
    always_comb begin
        value_clamped = value;
        if (value <= X_MIN_V) begin
            value_clamped = X_MIN_V;
        end else if (value >= X_MAX_V) begin
            value_clamped = X_MAX_V;
        end
    end

    // ------------------------------------------------------------------
    // Parser next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        bad_nxt   = bad_q;
        accept    = 1'b0;
        reject    = 1'b0;

        if ((state != S_HDR) && (rx_error || timed_out)) begin
            // Abort of a partially received packet.
            reject    = 1'b1;
            state_nxt = S_HDR;
        end else begin
            case (state)
                S_HDR: begin
                    // Non-sync bytes are dropped silently to resynchronise.
                    if (byte_ok && (rx_data == SYNC_BYTE)) begin
                        state_nxt = S_HI;
                        bad_nxt   = 1'b0;
                    end
                end
                S_HI: begin
                    if (byte_ok) begin
                        hi_nxt    = rx_data;
                        // Out-of-range HI marks the packet bad, but the frame
                        // is still consumed so the parser stays aligned.
                        bad_nxt   = |rx_data[7:2];
                        state_nxt = S_LO;
                    end
                end
                S_LO: begin
                    if (byte_ok) begin
                        lo_nxt    = rx_data;
                        state_nxt = S_CHK;
                    end
                end
                S_CHK: begin
                    if (byte_ok) begin
                        state_nxt = S_HDR;
                        if ((rx_data == (hi_q ^ lo_q ^ SYNC_BYTE)) && !bad_q) begin
                            accept = 1'b1;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = S_HDR;
                end
            endcase
        end

        // Idle counter restarts on every byte strobe and whenever the parser
        // is (or is about to be) waiting for a header.
        if ((state_nxt == S_HDR) || rx_valid) begin
            tmo_nxt = 16'd0;
        end else begin
            tmo_nxt = tmo_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Position update (uses the target_x value before this edge)
    // ------------------------------------------------------------------
`ifdef CANASTA_SLEW_EN
    localparam logic [9:0] STEP_V = 10'(STEP);
    logic       move_up;
    logic [9:0] dist;
    logic [9:0] step_amt;

    always_comb begin
        move_up  = (target_x >= pos_x);
        // Distance is formed with the larger operand first so it never wraps.
        dist     = move_up ? (target_x - pos_x) : (pos_x - target_x);
        step_amt = (dist > STEP_V) ? STEP_V : dist;
        pos_nxt  = move_up ? (pos_x + step_amt) : (pos_x - step_amt);
    end
`else
    logic unused_step;
    assign unused_step = ^10'(STEP);

    always_comb begin
        pos_nxt = target_x;
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_HDR;
            hi_q      <= 8'd0;
            lo_q      <= 8'd0;
            bad_q     <= 1'b0;
            tmo_cnt   <= 16'd0;
            target_x  <= RESET_X_V;
            pos_x     <= RESET_X_V;
            pkt_ok    <= 1'b0;
            pkt_err   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state   <= state_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            bad_q   <= bad_nxt;
            tmo_cnt <= tmo_nxt;
            pkt_ok  <= accept;
            pkt_err <= reject;

            if (accept) begin
                target_x <= value_clamped;
            end

            if (reject && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            if (frame_tick) begin
                pos_x <= pos_nxt;
            end
        end
    end

    assign busy = (state != S_HDR);

endmodule
`default_nettype wire

// File: tb/tb_canasta_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_canasta_ctrl
// Purpose  : Self-checking bench for canasta_ctrl. A packet-level reference
//            model (byte queue + idle counter) predicts every output each
//            cycle; directed sequences add checks against fixed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_canasta_ctrl;

    localparam int X_MIN   = 0;
    localparam int X_MAX   = 575;
    localparam int RESET_X = 288;
    localparam int STEP    = 4;
    localparam int TIMEOUT = 50000;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       rx_valid   = 1'b0;
    logic [7:0] rx_data    = 8'd0;
    logic       rx_error   = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] pos_x;
    logic [9:0] target_x;
    logic       pkt_ok;
    logic       pkt_err;
    logic [7:0] err_count;
    logic       busy;

    canasta_ctrl #(
        .X_MIN   (X_MIN),
        .X_MAX   (X_MAX),
        .RESET_X (RESET_X),
        .STEP    (STEP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_error   (rx_error),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .target_x   (target_x),
        .pkt_ok     (pkt_ok),
        .pkt_err    (pkt_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         m_pos  = RESET_X;
    int         m_tgt  = RESET_X;
    int         m_errc = 0;
    bit         m_ok   = 1'b0;
    bit         m_err  = 1'b0;
    logic [7:0] q[$];
    int         idle   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int clampv(input int v);
        if (v > X_MAX) return X_MAX;
        if (v < X_MIN) return X_MIN;
        return v;
    endfunction

    task automatic model_reset();
        m_pos  = RESET_X;
        m_tgt  = RESET_X;
        m_errc = 0;
        m_ok   = 1'b0;
        m_err  = 1'b0;
        q.delete();
        idle   = 0;
    endtask

    task automatic model_reject();
        m_err = 1'b1;
        if (m_errc < 255) m_errc++;
        q.delete();
    endtask

    // One clock edge of the behavioural model.
    task automatic model_step(input logic v, input logic [7:0] d, input logic e, input logic t);
        int new_pos;
        logic [7:0] hi, lo, ck;
        m_ok  = 1'b0;
        m_err = 1'b0;
        new_pos = m_pos;
        if (t) begin
`ifdef CANASTA_SLEW_EN
            if (m_tgt - m_pos > STEP)       new_pos = m_pos + STEP;
            else if (m_pos - m_tgt > STEP)  new_pos = m_pos - STEP;
            else                            new_pos = m_tgt;
`else
            new_pos = m_tgt;
`endif
        end
        if (q.size() > 0) begin
            if (e) begin
                model_reject();
            end else if (v) begin
                q.push_back(d);
                idle = 0;
                if (q.size() == 4) begin
                    hi = q[1];
                    lo = q[2];
                    ck = q[3];
                    if (hi[7:2] == 6'd0 && ck == (hi ^ lo ^ 8'hAA)) begin
                        m_ok  = 1'b1;
                        m_tgt = clampv(int'({hi[1:0], lo}));
                        q.delete();
                    end else begin
                        model_reject();
                    end
                end
            end else begin
                idle++;
                if (idle == TIMEOUT) model_reject();
            end
        end else if (v && !e && d == 8'hAA) begin
            q.push_back(d);
            idle = 0;
        end
        m_pos = new_pos;
    endtask

    task automatic compare_all();
        check("pos_x",     pos_x,     m_pos);
        check("target_x",  target_x,  m_tgt);
        check("pkt_ok",    pkt_ok,    m_ok);
        check("pkt_err",   pkt_err,   m_err);
        check("err_count", err_count, m_errc);
        check("busy",      busy,      q.size() != 0);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic t);
        rx_valid   = v;
        rx_data    = d;
        rx_error   = e;
        frame_tick = t;
        @(posedge clk);
        model_step(v, d, e, t);
        #1;
        compare_all();
        rx_valid   = 1'b0;
        rx_error   = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        drive(1'b1, a, 1'b0, 1'b0);
        drive(1'b1, b, 1'b0, 1'b0);
        drive(1'b1, c, 1'b0, 1'b0);
        drive(1'b1, d, 1'b0, 1'b0);
    endtask

    // Random byte with random leading gap, frame ticks and rare errors.
    task automatic rbyte(input logic [7:0] d);
        int gap;
        gap = int'($urandom % 3);
        for (int i = 0; i < gap; i++) begin
            drive(1'b0, 8'($urandom), ($urandom % 60) == 0, ($urandom % 6) == 0);
        end
        drive(1'b1, d, ($urandom % 60) == 0, ($urandom % 6) == 0);
    endtask

    initial begin
        logic [9:0] v;
        logic [7:0] hi, lo, ck;
        int kind;

        // Reset
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_pos_x",    pos_x,     RESET_X);
        check("rst_target_x", target_x,  RESET_X);
        check("rst_pkt_ok",   pkt_ok,    0);
        check("rst_pkt_err",  pkt_err,   0);
        check("rst_err_cnt",  err_count, 0);
        check("rst_busy",     busy,      0);
        reset = 1'b1;
        drive(1'b0, 8'd0, 1'b0, 1'b0);

        // Valid packet, value 288
        send4(8'hAA, 8'h01, 8'h20, 8'h8B);
        check("pkt1_ok", pkt_ok, 1);
        check("pkt1_tgt", target_x, 288);
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        check("pkt1_pos", pos_x, 288);

        // Value 512 then move
        send4(8'hAA, 8'h02, 8'h00, 8'hA8);
        check("pkt2_tgt", target_x, 512);
        drive(1'b0, 8'd0, 1'b0, 1'b1);
`ifdef CANASTA_SLEW_EN
        check("slew_first", pos_x, 292);
`else
        check("jump_first", pos_x, 512);
`endif
        repeat (55) drive(1'b0, 8'd0, 1'b0, 1'b1);
        check("pos_512", pos_x, 512);

        // Clamp
        send4(8'hAA, 8'h03, 8'hFF, 8'h56);
        check("clamp_ok", pkt_ok, 1);
        check("clamp_tgt", target_x, 575);

        // Bad checksum, bad HI
        send4(8'hAA, 8'h01, 8'h20, 8'h00);
        check("badchk_err", pkt_err, 1);
        check("badchk_cnt", err_count, 1);
        send4(8'hAA, 8'h04, 8'h00, 8'hAE);
        check("badhi_err", pkt_err, 1);
        check("badhi_cnt", err_count, 2);
        check("bad_tgt", target_x, 575);

        // Resync through garbage
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'h13, 1'b0, 1'b0);
        send4(8'hAA, 8'h00, 8'h10, 8'hBA);
        check("resync_ok", pkt_ok, 1);
        check("resync_tgt", target_x, 16);

        // Timeout in S_LO
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        repeat (TIMEOUT - 1) drive(1'b0, 8'd0, 1'b0, 1'b0);
        check("tmo_not_yet", pkt_err, 0);
        check("tmo_busy_pre", busy, 1);
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        check("tmo_err", pkt_err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_cnt", err_count, 3);

        // rx_error in S_LO
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        check("rxerr_err", pkt_err, 1);
        check("rxerr_busy", busy, 0);

        // Frame tick on the acceptance edge uses the previous target
        repeat (200) drive(1'b0, 8'd0, 1'b0, 1'b1);
        check("settle_16", pos_x, 16);
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        drive(1'b1, 8'h8B, 1'b0, 1'b1);
        check("simul_pos", pos_x, 16);
        check("simul_tgt", target_x, 288);

        // Randomized traffic
        for (int p = 0; p < 400; p++) begin
            kind = int'($urandom % 4);
            v  = 10'($urandom_range(0, 1023));
            hi = {6'd0, v[9:8]};
            lo = v[7:0];
            ck = hi ^ lo ^ 8'hAA;
            if (kind == 1) ck = ck ^ 8'($urandom_range(1, 255));
            if (kind == 2) hi = {6'($urandom_range(1, 63)), v[9:8]};
            if (kind == 3) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) rbyte(8'($urandom));
            end else begin
                rbyte(8'hAA);
                rbyte(hi);
                rbyte(lo);
                rbyte(ck);
            end
        end
        repeat (4) drive(1'b0, 8'd0, 1'b0, 1'b0);

        // Saturation
        repeat (300) send4(8'hAA, 8'h01, 8'h20, 8'h00);
        check("sat_cnt", err_count, 255);

        // Reset mid-packet
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("mrst_pos_x",   pos_x,     RESET_X);
        check("mrst_target",  target_x,  RESET_X);
        check("mrst_err_cnt", err_count, 0);
        check("mrst_busy",    busy,      0);
        @(posedge clk);
        #1;
        check("mrst_pkt_ok",  pkt_ok,  0);
        check("mrst_pkt_err", pkt_err, 0);
        #2;
        reset = 1'b1;
        repeat (3) drive(1'b0, 8'd0, 1'b0, 1'b0);
        send4(8'hAA, 8'h00, 8'h10, 8'hBA);
        check("post_rst_tgt", target_x, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
